// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path definitions: bus widths, reset polarity and the buffered
// {pc, inst} entry layout used between the fetch unit and its FIFOs.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic                   RstEnable     = 1'b1;
  localparam logic [InstBus-1:0]     ZeroWord      = 32'h0000_0000;
  localparam logic [InstAddrBus-1:0] InstAlignMask = 32'hFFFF_FFFC;
  localparam logic [InstAddrBus-1:0] InstStep      = 32'h0000_0004;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] align_addr(input logic [InstAddrBus-1:0] addr);
    return addr & InstAlignMask;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is visible combinationally so the
// consumer sees data in the cycle after it was pushed.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != FullCount) || do_pop_s);

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == FullCount);
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches over req/gnt/rvalid,
// pairs returned words with their address and feeds the fetch/decode register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  output logic                   if_valid_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthOcc = (CW + 1)'(DEPTH);

  logic [InstAddrBus-1:0] pc_r;
  logic [CW-1:0]          drop_cnt_r;
  logic [CW-1:0]          outstanding_s;
  logic [CW-1:0]          buffered_s;
  logic [CW-1:0]          outstanding_after_s;
  logic [CW:0]            occupancy_s;
  logic                   aq_full_s;
  logic                   aq_empty_s;
  logic                   ib_full_s;
  logic                   ib_empty_s;
  logic                   transfer_s;
  logic                   resp_s;
  logic                   keep_s;
  logic                   pop_s;
  logic [InstAddrBus-1:0] tag_s;
  fetch_entry_t           push_entry_s;
  fetch_entry_t           head_s;

  // Occupancy counts dropped-to-be requests too, so credit is never over-issued.
  assign occupancy_s = {1'b0, outstanding_s} + {1'b0, buffered_s};
  assign transfer_s  = imem_req_o && imem_gnt_i;
  assign resp_s      = imem_rvalid_i && !aq_empty_s;
  assign keep_s      = resp_s && (drop_cnt_r == '0) && !branch_flag_i;
  assign pop_s       = !ib_empty_s && !stall_i && !branch_flag_i;
  assign outstanding_after_s = resp_s ? (outstanding_s - 1'b1) : outstanding_s;
  assign push_entry_s = '{pc: tag_s, inst: imem_rdata_i};
  assign imem_addr_o  = pc_r;

  fetch_fifo #(.WIDTH(InstAddrBus), .DEPTH(DEPTH)) u_addr_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (transfer_s),
    .push_data (pc_r),
    .pop       (resp_s),
    .head      (tag_s),
    .full      (aq_full_s),
    .empty     (aq_empty_s),
    .count     (outstanding_s)
  );

  fetch_fifo #(.WIDTH(InstAddrBus + InstBus), .DEPTH(DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_flag_i),
    .push      (keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (ib_full_s),
    .empty     (ib_empty_s),
    .count     (buffered_s)
  );

  // Request gating: held low in reset and on redirect, otherwise credit-limited.
  always_comb begin
    imem_req_o = 1'b0;
    if (rst == RstEnable || branch_flag_i) begin
      imem_req_o = 1'b0;
    end else if ((occupancy_s < DepthOcc) && !aq_full_s && !ib_full_s) begin
      imem_req_o = 1'b1;
    end else begin
      imem_req_o = 1'b0;
    end
  end

  // Program counter: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_r <= RESET_PC;
    end else if (branch_flag_i) begin
      pc_r <= align_addr(branch_target_i);
    end else if (transfer_s) begin
      pc_r <= pc_r + InstStep;
    end
  end

  // Everything still in flight after a redirect belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      drop_cnt_r <= '0;
    end else if (branch_flag_i) begin
      drop_cnt_r <= outstanding_after_s;
    end else if (resp_s && (drop_cnt_r != '0)) begin
      drop_cnt_r <= drop_cnt_r - 1'b1;
    end
  end

  // Presented pair is forced to zero whenever the buffer is empty.
  always_comb begin
    if_valid_o = !ib_empty_s;
    if_pc_o    = ZeroWord;
    if_inst_o  = ZeroWord;
    if (!ib_empty_s) begin
      if_pc_o   = head_s.pc;
      if_inst_o = head_s.inst;
    end else begin
      if_pc_o   = ZeroWord;
      if_inst_o = ZeroWord;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: scripted memory models, a per-cycle vector
// table for reset/stream/stall, and hand sequences for branch, reset and wrap.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_valid;

  int checks;
  int failures;
  int grants;
  int grant_all;
  int lat_fixed;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic        req;
  } vec_t;

  vec_t vecs [16];

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch_flag),
    .branch_target_i(branch_target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .if_pc_o(if_pc), .if_inst_o(if_inst), .if_valid_o(if_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_i(32'h0000_0000), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .if_pc_o(w_pc), .if_inst_o(w_inst), .if_valid_o(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Main memory: in-order responses, fixed or random latency, optional random grant.
  initial begin
    pend_t pend [$];
    pend_t ent;
    int    mem_cyc;
    int    lat;
    mem_cyc = 0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      mem_cyc++;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      if (rst) begin
        pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due <= mem_cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend[0].addr);
          void'(pend.pop_front());
        end
        if (imem_req && (grant_all != 0 || $urandom_range(0, 1) == 1)) begin
          imem_gnt = 1'b1;
          lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
          ent.addr = imem_addr;
          ent.due  = mem_cyc + lat;
          pend.push_back(ent);
          grants++;
        end
      end
    end
  end

  // Wrap-test memory: always grants, answers exactly one cycle later.
  initial begin
    logic        pg;
    logic [31:0] pa;
    pg = 1'b0; pa = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0; pg = 1'b0;
      end else begin
        w_rvalid = pg;
        w_rdata  = pg ? mem_word(pa) : 32'h0;
        w_gnt    = w_req;
        pg       = w_req;
        pa       = w_addr;
      end
    end
  end

  // Leaves the bench at the negedge that starts cycle 0 with rst released.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc",    if_pc,         32'h0);
    check("rst_inst",  if_inst,       32'h0);
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_wreq",  32'(w_req),    32'h0);
    @(negedge clk);
    grants = 0;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pops;
    int          received;
    checks = 0; failures = 0; grants = 0;
    grant_all = 1; lat_fixed = 1;
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;

    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h00, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h04, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h08, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h08, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h08, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h08, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h08, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h08, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h08, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0C, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h10, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h14, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h18, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 32'h1C, 1'b1};

    // Free-running 1-cycle memory with a 6-cycle stall on pc=8; wrap DUT alongside.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall;
      #1;
      check($sformatf("tab%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
      check($sformatf("tab%0d_pc", i), if_pc, vecs[i].pc);
      check($sformatf("tab%0d_inst", i), if_inst, vecs[i].valid ? mem_word(vecs[i].pc) : 32'h0);
      check($sformatf("tab%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (i >= 2 && i <= 5) begin
        exp_pc = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        check($sformatf("wrap%0d_valid", i), 32'(w_valid), 32'h1);
        check($sformatf("wrap%0d_pc", i), w_pc, exp_pc);
        check($sformatf("wrap%0d_inst", i), w_inst, mem_word(exp_pc));
      end
      @(negedge clk);
    end
    stall = 1'b0;

    // Branch to 0x103 with two requests in flight (2-cycle memory).
    lat_fixed = 2;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      branch_flag   = (c == 3);
      branch_target = 32'h0000_0103;
      #1;
      if (c == 2) check("br_c2_valid", 32'(if_valid), 32'h0);
      if (c == 3) begin
        check("br_c3_valid", 32'(if_valid), 32'h1);
        check("br_c3_pc", if_pc, 32'h0);
        check("br_c3_req", 32'(imem_req), 32'h0);
      end
      if (c == 4) begin
        check("br_c4_req", 32'(imem_req), 32'h1);
        check("br_c4_addr", imem_addr, 32'h0000_0100);
      end
      if (c >= 4 && c <= 6) check($sformatf("br_c%0d_valid", c), 32'(if_valid), 32'h0);
      if (c == 7) begin
        check("br_c7_valid", 32'(if_valid), 32'h1);
        check("br_c7_pc", if_pc, 32'h0000_0100);
        check("br_c7_inst", if_inst, mem_word(32'h0000_0100));
      end
      if (c == 8) check("br_c8_pc", if_pc, 32'h0000_0104);
      @(negedge clk);
    end
    branch_flag = 1'b0;

    // Reset asserted for one cycle with three requests in flight (3-cycle memory).
    lat_fixed = 3;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      rst = (c == 5);
      #1;
      if (c == 4) check("mr_c4_pc", if_pc, 32'h0);
      if (c == 5) check("mr_c5_req", 32'(imem_req), 32'h0);
      if (c == 6) begin
        check("mr_c6_valid", 32'(if_valid), 32'h0);
        check("mr_c6_req", 32'(imem_req), 32'h1);
        check("mr_c6_addr", imem_addr, 32'h0);
      end
      if (c == 8) check("mr_c8_valid", 32'(if_valid), 32'h0);
      if (c == 10) begin
        check("mr_c10_valid", 32'(if_valid), 32'h1);
        check("mr_c10_pc", if_pc, 32'h0);
        check("mr_c10_inst", if_inst, mem_word(32'h0));
      end
      @(negedge clk);
    end
    rst = 1'b0;

    // Random grant, 1-5 cycle latency, random stalls: contiguous stream, bounded occupancy.
    grant_all = 0; lat_fixed = 0;
    do_reset();
    exp_pc = 32'h0; pops = 0; received = 0;
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      #1;
      check("rand_occ_le4", 32'((grants - pops) <= 4), 32'h1);
      if (if_valid) begin
        check("rand_pc", if_pc, exp_pc);
        check("rand_inst", if_inst, mem_word(exp_pc));
        if (!stall) begin
          pops++;
          received++;
          exp_pc = exp_pc + 32'h4;
        end
      end
      @(negedge clk);
    end
    stall = 1'b0;
    check("rand_progress", 32'(received >= 50), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
